// File: rtl/mic_delay_sum.sv
// Two-channel delay-and-sum stage: per-channel circular history with a
// programmable integer-sample delay, averaged into one mono output sample.
module mic_delay_sum #(
  parameter int unsigned DEPTH_LOG2 = 5,
  parameter int unsigned SAMPLE_W   = 16
) (
  input  logic                  clock_in,
  input  logic                  reset_n_in,
  input  logic [SAMPLE_W-1:0]   left_sample_in,
  input  logic [SAMPLE_W-1:0]   right_sample_in,
  input  logic                  new_sample_in,
  input  logic [DEPTH_LOG2-1:0] delay_left_in,
  input  logic [DEPTH_LOG2-1:0] delay_right_in,
  output logic [SAMPLE_W-1:0]   sum_sample_out,
  output logic                  sum_valid_out,
  output logic                  busy_out,
  output logic [7:0]            drop_count_out
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned SUM_W  = SAMPLE_W + 1;
  localparam int unsigned DROP_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_SUM  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [SAMPLE_W-1:0]   r_hist_l [DEPTH];
  logic [SAMPLE_W-1:0]   r_hist_r [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wp;
  logic [DEPTH_LOG2-1:0] r_dl;
  logic [DEPTH_LOG2-1:0] r_dr;
  logic [SAMPLE_W-1:0]   r_rd_l;
  logic [SAMPLE_W-1:0]   r_rd_r;
  logic [SAMPLE_W-1:0]   r_sum;
  logic                  r_valid;
  logic                  r_busy;
  logic [DROP_W-1:0]     r_drop;

  logic                  w_accept;
  logic                  w_read;
  logic                  w_sum;
  logic                  w_drop;
  logic [DEPTH_LOG2-1:0] w_addr_l;
  logic [DEPTH_LOG2-1:0] w_addr_r;
  logic [SUM_W-1:0]      w_sum_full;

  // State register
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (new_sample_in) w_state_nxt = S_READ;
      S_READ:  w_state_nxt = S_SUM;
      S_SUM:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Per-state datapath strobes; a pulse arriving while busy is counted and ignored
  always_comb begin
    w_accept = 1'b0;
    w_read   = 1'b0;
    w_sum    = 1'b0;
    w_drop   = 1'b0;
    case (r_state)
      S_IDLE: w_accept = new_sample_in;
      S_READ: begin
        w_read = 1'b1;
        w_drop = new_sample_in;
      end
      S_SUM: begin
        w_sum  = 1'b1;
        w_drop = new_sample_in;
      end
      default: ;
    endcase
  end

  // Read addresses wrap modulo the history depth
  assign w_addr_l = r_wp - r_dl;
  assign w_addr_r = r_wp - r_dr;

  // One extra bit of headroom, then floor-halve: the average cannot overflow
  assign w_sum_full = {r_rd_l[SAMPLE_W-1], r_rd_l} + {r_rd_r[SAMPLE_W-1], r_rd_r};

  // Sample history, cleared on reset so unfilled slots read as zero
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_hist_l[i] <= '0;
        r_hist_r[i] <= '0;
      end
    end else if (w_accept) begin
      r_hist_l[r_wp] <= left_sample_in;
      r_hist_r[r_wp] <= right_sample_in;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_wp   <= '0;
      r_dl   <= '0;
      r_dr   <= '0;
      r_rd_l <= '0;
      r_rd_r <= '0;
    end else begin
      if (w_accept) begin
        r_dl <= delay_left_in;
        r_dr <= delay_right_in;
      end
      if (w_read) begin
        r_rd_l <= r_hist_l[w_addr_l];
        r_rd_r <= r_hist_r[w_addr_r];
      end
      if (w_sum) begin
        r_wp <= r_wp + DEPTH_LOG2'(1);
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clock_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_sum   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_drop  <= '0;
    end else begin
      r_valid <= w_sum;
      r_busy  <= (w_state_nxt != S_IDLE);
      if (w_sum) begin
        r_sum <= w_sum_full[SUM_W-1:1];
      end
      if (w_drop && (r_drop != {DROP_W{1'b1}})) begin
        r_drop <= r_drop + DROP_W'(1);
      end
    end
  end

  assign sum_sample_out = r_sum;
  assign sum_valid_out  = r_valid;
  assign busy_out       = r_busy;
  assign drop_count_out = r_drop;

endmodule

// File: tb/tb_mic_delay_sum.sv
// Scoreboard bench for mic_delay_sum: a reference history model predicts each
// averaged sample and the cycle its valid pulse must appear.
module tb_mic_delay_sum;

  localparam int unsigned DL2   = 5;
  localparam int unsigned SW    = 16;
  localparam int unsigned DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] left_in = '0;
  logic [SW-1:0] right_in = '0;
  logic          new_in = 1'b0;
  logic [DL2-1:0] dl_in = '0;
  logic [DL2-1:0] dr_in = '0;
  logic [SW-1:0] sum_out;
  logic          valid_out;
  logic          busy_out;
  logic [7:0]    drop_out;

  mic_delay_sum #(.DEPTH_LOG2(DL2), .SAMPLE_W(SW)) dut (
    .clock_in       (clk),
    .reset_n_in     (rst_n),
    .left_sample_in (left_in),
    .right_sample_in(right_in),
    .new_sample_in  (new_in),
    .delay_left_in  (dl_in),
    .delay_right_in (dr_in),
    .sum_sample_out (sum_out),
    .sum_valid_out  (valid_out),
    .busy_out       (busy_out),
    .drop_count_out (drop_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] sum;
    int unsigned   cyc;
  } exp_t;

  exp_t        q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  logic [SW-1:0] m_hist_l [DEPTH];
  logic [SW-1:0] m_hist_r [DEPTH];
  int          m_wp = 0;
  int          m_drop = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_hist_l[i] = '0;
      m_hist_r[i] = '0;
    end
    m_wp   = 0;
    m_drop = 0;
    q.delete();
  endtask

  // Reference: write, read back by delay, floor-average in plain integers
  task automatic model_accept(input logic [SW-1:0] l, input logic [SW-1:0] r,
                              input int dl, input int dr);
    int a, b, s;
    exp_t e;
    m_hist_l[m_wp] = l;
    m_hist_r[m_wp] = r;
    a = int'($signed(m_hist_l[(m_wp + int'(DEPTH) - dl) % int'(DEPTH)]));
    b = int'($signed(m_hist_r[(m_wp + int'(DEPTH) - dr) % int'(DEPTH)]));
    s = (a + b) >>> 1;
    e.sum = SW'(s);
    e.cyc = cyc + 3;
    q.push_back(e);
    m_wp = (m_wp + 1) % int'(DEPTH);
  endtask

  // Called #1 after a posedge; returns #1 after the SUM edge so the next call
  // lands its pulse in the cycle the FSM is back in IDLE.
  task automatic send(input logic [SW-1:0] l, input logic [SW-1:0] r,
                      input int dl, input int dr, input bit collide);
    left_in  = l;
    right_in = r;
    dl_in    = DL2'(dl);
    dr_in    = DL2'(dr);
    new_in   = 1'b1;
    model_accept(l, r, dl, dr);
    @(posedge clk); #1;
    new_in   = collide;
    left_in  = SW'($urandom);
    right_in = SW'($urandom);
    dl_in    = DL2'($urandom);
    dr_in    = DL2'($urandom);
    if (collide && m_drop < 255) m_drop++;
    @(posedge clk); #1;
    new_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    idle(2);
    rst_n = 1'b0;
    model_reset();
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Output monitor: every valid pulse must match the oldest prediction
  always @(negedge clk) begin
    if (valid_out) begin
      if (q.size() == 0) begin
        check_eq("spurious_valid", 32'(valid_out), 32'(0));
      end else begin
        exp_t e;
        e = q.pop_front();
        check_eq("sum", 32'(sum_out), 32'(e.sum));
        check_eq("valid_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #3;
    check_eq("rst_sum", 32'(sum_out), 32'(0));
    check_eq("rst_valid", 32'(valid_out), 32'(0));
    check_eq("rst_busy", 32'(busy_out), 32'(0));
    check_eq("rst_drop", 32'(drop_out), 32'(0));
    #9;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single pair, busy profile and hold of the result
    left_in = 16'h1000; right_in = 16'h3000; dl_in = '0; dr_in = '0; new_in = 1'b1;
    model_accept(16'h1000, 16'h3000, 0, 0);
    @(negedge clk);
    check_eq("busy_t0", 32'(busy_out), 32'(0));
    @(posedge clk); #1;
    new_in = 1'b0;
    @(negedge clk);
    check_eq("busy_t1", 32'(busy_out), 32'(1));
    @(negedge clk);
    check_eq("busy_t2", 32'(busy_out), 32'(1));
    @(negedge clk);
    check_eq("busy_t3", 32'(busy_out), 32'(0));
    repeat (3) @(negedge clk);
    check_eq("hold_sum", 32'(sum_out), 32'h2000);
    check_eq("hold_valid", 32'(valid_out), 32'(0));
    @(posedge clk); #1;

    // Extremes with zero delay
    send(16'h7FFF, 16'h7FFF, 0, 0, 0);
    send(16'h8000, 16'h8000, 0, 0, 0);
    send(16'h0001, 16'hFFFE, 0, 0, 0);
    idle(2);
    check_eq("floor_neg_half", 32'(sum_out), 32'hFFFF);

    // Left delayed by 3 against an undelayed silent right channel
    do_reset();
    for (int i = 0; i < 10; i++) send(SW'(i + 1), 16'h0000, 3, 0, 0);

    // Maximum delay across pointer wrap
    do_reset();
    for (int n = 0; n < 40; n++) send(SW'(n), SW'(n), 31, 31, 0);
    idle(2);
    check_eq("wrap_last", 32'(sum_out), 32'(39 - 31));

    // One collision, then reset during READ with a full history
    send(16'h0100, 16'h0100, 0, 0, 1);
    check_eq("drop_one", 32'(drop_out), 32'(m_drop));
    idle(2);
    left_in = 16'h1234; right_in = 16'h5678; dl_in = '0; dr_in = '0; new_in = 1'b1;
    @(posedge clk); #1;
    new_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_sum", 32'(sum_out), 32'(0));
    check_eq("midrst_valid", 32'(valid_out), 32'(0));
    check_eq("midrst_busy", 32'(busy_out), 32'(0));
    check_eq("midrst_drop", 32'(drop_out), 32'(0));
    model_reset();
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h0600, 16'h0600, 1, 1, 0);
    send(16'h0400, 16'h0200, 0, 5, 0);
    send(16'h0100, 16'h0300, 1, 0, 0);

    // Drop counter saturation
    do_reset();
    for (int i = 1; i <= 300; i++) begin
      send(SW'(i), SW'(16'h8000 - i), i % 32, (i * 7) % 32, 1);
      check_eq("drop_count", 32'(drop_out), 32'(m_drop));
    end
    check_eq("drop_sat", 32'(drop_out), 32'(255));

    // Drain outstanding predictions
    for (int i = 0; i < 10 && q.size() != 0; i++) idle(1);
    idle(3);
    check_eq("drain", 32'(q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mic_delay_sum.md
Name: mic_delay_sum

Overview:
- Downstream consumer of the two-microphone I2S receiver's left/right sample pair and new-sample pulse.
- Keeps a short circular history per channel and applies a programmable integer-sample delay to each channel.
- Outputs the averaged (delay-and-sum) mono sample with a one-cycle valid pulse.
- First stage of the beamforming path; feeds the downstream filter/output chain.

Parameters:
- DEPTH_LOG2, 5, log2 of history depth per channel (32 samples); max delay 2^DEPTH_LOG2 - 1.
- SAMPLE_W, 16, sample width, two's complement.

Ports:
- clock_in  input  1  100 MHz system clock
- reset_n_in  input  1  asynchronous active-low reset
- left_sample_in  input  SAMPLE_W  left mic sample, valid when new_sample_in=1
- right_sample_in  input  SAMPLE_W  right mic sample, valid when new_sample_in=1
- new_sample_in  input  1  one-cycle pulse, new pair present
- delay_left_in  input  DEPTH_LOG2  left channel delay in samples
- delay_right_in  input  DEPTH_LOG2  right channel delay in samples
- sum_sample_out  output  SAMPLE_W  delay-and-sum result, two's complement
- sum_valid_out  output  1  one-cycle pulse, sum_sample_out updated
- busy_out  output  1  high while a pair is being processed
- drop_count_out  output  8  saturating count of pulses dropped while busy

Behaviour:
- Reset (async, reset_n_in=0):
  - all outputs 0; write pointer wp=0; state IDLE.
  - Both history arrays cleared to 0, so reads before history fills return 0.
- State machine IDLE -> READ -> SUM -> IDLE; busy_out=1 in READ and SUM.
- IDLE, new_sample_in=1 at cycle T:
  - write left/right into buffers at address wp.
  - latch delay_left_in/delay_right_in into dl/dr.
  - go to READ.
- READ (T+1):
  - register buffer reads at (wp - dl) mod 2^DEPTH_LOG2 and (wp - dr) mod 2^DEPTH_LOG2; pointer subtraction wraps naturally.
  - Delay 0 returns the sample written at T.
  - go to SUM.
- SUM (T+2):
  - sum = sign-extended SAMPLE_W+1-bit add of both reads, arithmetic shift right 1 (floor); cannot overflow.
  - register into sum_sample_out; sum_valid_out=1 at T+3 for exactly one cycle.
  - wp <= wp+1 (wraps 31->0); go to IDLE.
- Latency: new_sample_in at T -> sum_valid_out high at T+3. Back-to-back pulses are accepted if spaced >=3 cycles; the I2S rate is ~1 per 1536 cycles.
- new_sample_in while busy (READ/SUM):
  - sample dropped; no buffer write.
  - drop_count_out increments, saturating at 255.
  - in-progress computation unaffected.
- new_sample_in in the same cycle the FSM returns to IDLE is accepted normally.
- Delay input changes outside the IDLE accept cycle have no effect on the current result.
- sum_sample_out holds its value between valid pulses.
- Reset asserted mid-operation: immediate return to IDLE; no valid pulse; history cleared.

Test Plan:
- Reset, dl=dr=0, one pair L=0x1000 R=0x3000 -> sum_valid_out exactly 3 cycles after pulse, sum=0x2000, busy_out high 2 cycles.
- Extremes, delays 0: (0x7FFF,0x7FFF) -> 0x7FFF; (0x8000,0x8000) -> 0x8000; (0x0001,0xFFFE) -> 0xFFFF (floor of -0.5).
- dl=3, dr=0, left stream 1,2,3,... (10 pairs), right=0 -> 1st-3rd outputs 0 (unfilled history), 4th output 0x0000 (1>>>1), 5th 0x0001 (2>>>1).
- Wrap: 40 pairs with left=index, dl=31, dr=31, right=left -> output n equals n-31 for n>=31 across wp wrap; output 0 for n<31.
- Drop: second new_sample_in 1 cycle after the first -> no extra valid, drop_count_out=1; 300 such collisions -> saturates at 255.
- Async reset pulse during READ -> outputs 0 immediately, no sum_valid_out; next pair with delay 0 gives correct sum and delay 1 gives 0.
